// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: request/ack data-memory transaction with byte lanes and load extension.
// Optional bus timeout when DMEM_TIMEOUT_EN is defined.
module mem_access_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        valid_i,
  input  logic        mem_write_i,
  input  logic        mem_read_i,
  input  logic [2:0]  dm_type_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        stall_o,
  output logic [31:0] rdata_o,
  output logic        rdata_valid_o,
  output logic        misalign_o,
  output logic        err_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_ack_i,
  input  logic [31:0] dmem_rdata_i
);

  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be nonzero");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state_q;
  logic        req_q, we_q, rvalid_q;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [3:0]  be_q;
  logic [2:0]  type_q;
  logic [1:0]  off_q;

  logic        start, aligned, is_half, is_byte;
  logic [2:0]  type_d;
  logic [3:0]  be_d;
  logic [31:0] wdata_d, ld_d;
  logic [15:0] ld_half;
  logic [7:0]  ld_byte;

  assign start = valid_i & (mem_write_i | mem_read_i);

  // Unused codes fold to word; stores have no signedness, so fold unsigned onto signed.
  always_comb begin
    type_d = (dm_type_i > 3'd4) ? 3'd0 : dm_type_i;
    if (mem_write_i && type_d == 3'd2) type_d = 3'd1;
    if (mem_write_i && type_d == 3'd4) type_d = 3'd3;
  end

  assign is_half = (type_d == 3'd1) || (type_d == 3'd2);
  assign is_byte = (type_d == 3'd3) || (type_d == 3'd4);
  assign aligned = is_byte | (is_half & ~addr_i[0]) | (addr_i[1:0] == 2'b00);

  always_comb begin
    be_d    = 4'b1111;
    wdata_d = wdata_i;
    if (mem_write_i && is_byte) begin
      be_d    = 4'b0001 << addr_i[1:0];
      wdata_d = {4{wdata_i[7:0]}};
    end else if (mem_write_i && is_half) begin
      be_d    = 4'b0011 << {addr_i[1], 1'b0};
      wdata_d = {2{wdata_i[15:0]}};
    end
  end

  always_comb begin
    ld_half = off_q[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
    case (off_q)
      2'd0:    ld_byte = dmem_rdata_i[7:0];
      2'd1:    ld_byte = dmem_rdata_i[15:8];
      2'd2:    ld_byte = dmem_rdata_i[23:16];
      default: ld_byte = dmem_rdata_i[31:24];
    endcase
    case (type_q)
      3'd1:    ld_d = {{16{ld_half[15]}}, ld_half};
      3'd2:    ld_d = {16'h0000, ld_half};
      3'd3:    ld_d = {{24{ld_byte[7]}}, ld_byte};
      3'd4:    ld_d = {24'h000000, ld_byte};
      default: ld_d = dmem_rdata_i;
    endcase
  end

`ifdef DMEM_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CW-1:0] cnt_q;
  logic          err_q;
  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      rvalid_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      be_q     <= '0;
      type_q   <= '0;
      off_q    <= '0;
`ifdef DMEM_TIMEOUT_EN
      cnt_q    <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (start && aligned) begin
            req_q   <= 1'b1;
            we_q    <= mem_write_i;
            addr_q  <= {addr_i[31:2], 2'b00};
            be_q    <= be_d;
            wdata_q <= wdata_d;
            type_q  <= type_d;
            off_q   <= addr_i[1:0];
            state_q <= BUSY;
`ifdef DMEM_TIMEOUT_EN
            cnt_q   <= '0;
`endif
          end
        end
        BUSY: begin
          if (dmem_ack_i) begin
            req_q   <= 1'b0;
            state_q <= DONE;
            if (!we_q) begin
              rdata_q  <= ld_d;
              rvalid_q <= 1'b1;
            end
          end
`ifdef DMEM_TIMEOUT_EN
          else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
            req_q   <= 1'b0;
            err_q   <= 1'b1;
            rdata_q <= '0;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
`endif
        end
        DONE: begin
          rvalid_q <= 1'b0;
`ifdef DMEM_TIMEOUT_EN
          err_q    <= 1'b0;
`endif
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign misalign_o    = (state_q == IDLE) & start & ~aligned;
  assign stall_o       = rstn & (((state_q == IDLE) & start & aligned) | (state_q == BUSY));
  assign rdata_o       = rdata_q;
  assign rdata_valid_o = rvalid_q;
  assign dmem_req_o    = req_q;
  assign dmem_we_o     = we_q;
  assign dmem_addr_o   = addr_q;
  assign dmem_be_o     = be_q;
  assign dmem_wdata_o  = wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit; define DMEM_TIMEOUT_EN to also exercise the bus timeout.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rstn;
  logic        valid_i, mem_write_i, mem_read_i;
  logic [2:0]  dm_type_i;
  logic [31:0] addr_i, wdata_i;
  logic        stall_o, rdata_valid_o, misalign_o, err_o;
  logic [31:0] rdata_o;
  logic        dmem_req_o, dmem_we_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o;
  logic [3:0]  dmem_be_o;
  logic        dmem_ack_i;
  logic [31:0] dmem_rdata_i;

  int n_cmp = 0;
  int n_bad = 0;

`ifdef DMEM_TIMEOUT_EN
  localparam int DLY = 2;
`else
  localparam int DLY = 5;
`endif

  mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rstn(rstn),
    .valid_i(valid_i), .mem_write_i(mem_write_i), .mem_read_i(mem_read_i),
    .dm_type_i(dm_type_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .stall_o(stall_o), .rdata_o(rdata_o), .rdata_valid_o(rdata_valid_o),
    .misalign_o(misalign_o), .err_o(err_o),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o),
    .dmem_ack_i(dmem_ack_i), .dmem_rdata_i(dmem_rdata_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic drive(input logic wr, input logic rd, input logic [2:0] t,
                       input logic [31:0] a, input logic [31:0] d);
    valid_i = 1'b1; mem_write_i = wr; mem_read_i = rd;
    dm_type_i = t; addr_i = a; wdata_i = d;
  endtask

  initial begin
    rstn = 1'b0;
    valid_i = 1'b1; mem_write_i = 1'b0; mem_read_i = 1'b1;
    dm_type_i = 3'd0; addr_i = 32'h0; wdata_i = 32'h0;
    dmem_ack_i = 1'b0; dmem_rdata_i = 32'h0;
    #3;
    chk("rst_stall", 32'(stall_o), 32'd0);
    chk("rst_req", 32'(dmem_req_o), 32'd0);
    chk("rst_we", 32'(dmem_we_o), 32'd0);
    chk("rst_addr", dmem_addr_o, 32'h0);
    chk("rst_be", 32'(dmem_be_o), 32'h0);
    chk("rst_wdata", dmem_wdata_o, 32'h0);
    chk("rst_rdata", rdata_o, 32'h0);
    chk("rst_rvalid", 32'(rdata_valid_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    valid_i = 1'b0;
    smp();
    rstn = 1'b1;

    // lb 0x1003
    cyc(); drive(1'b0, 1'b1, 3'd3, 32'h0000_1003, 32'h0);
    smp(); chk("lb_c0_stall", 32'(stall_o), 32'd1); chk("lb_c0_req", 32'(dmem_req_o), 32'd0);
    cyc(); dmem_ack_i = 1'b1; dmem_rdata_i = 32'h80FF_1234;
    smp(); chk("lb_c1_req", 32'(dmem_req_o), 32'd1); chk("lb_c1_stall", 32'(stall_o), 32'd1);
    chk("lb_addr", dmem_addr_o, 32'h0000_1000); chk("lb_be", 32'(dmem_be_o), 32'hF);
    chk("lb_we", 32'(dmem_we_o), 32'd0);
    cyc(); dmem_ack_i = 1'b0;
    smp(); chk("lb_c2_rvalid", 32'(rdata_valid_o), 32'd1); chk("lb_rdata", rdata_o, 32'hFFFF_FF80);
    chk("lb_c2_stall", 32'(stall_o), 32'd0); chk("lb_c2_req", 32'(dmem_req_o), 32'd0);
    cyc(); valid_i = 1'b0;
    smp(); chk("lb_c3_rvalid", 32'(rdata_valid_o), 32'd0); chk("lb_hold", rdata_o, 32'hFFFF_FF80);

    // lhu 0x1002
    cyc(); drive(1'b0, 1'b1, 3'd2, 32'h0000_1002, 32'h0);
    smp(); chk("lhu_stall", 32'(stall_o), 32'd1);
    cyc(); dmem_ack_i = 1'b1; dmem_rdata_i = 32'h80FF_1234;
    smp();
    cyc(); dmem_ack_i = 1'b0;
    smp(); chk("lhu_rvalid", 32'(rdata_valid_o), 32'd1); chk("lhu_rdata", rdata_o, 32'h0000_80FF);
    cyc(); valid_i = 1'b0;

    // sb 0x2001
    cyc(); drive(1'b1, 1'b0, 3'd3, 32'h0000_2001, 32'h1234_56AB);
    smp(); chk("sb_stall", 32'(stall_o), 32'd1);
    cyc(); dmem_ack_i = 1'b1;
    smp(); chk("sb_be", 32'(dmem_be_o), 32'b0010); chk("sb_wdata", dmem_wdata_o, 32'hABAB_ABAB);
    chk("sb_addr", dmem_addr_o, 32'h0000_2000); chk("sb_we", 32'(dmem_we_o), 32'd1);
    cyc(); dmem_ack_i = 1'b0;
    smp(); chk("sb_rvalid", 32'(rdata_valid_o), 32'd0); chk("sb_rdata_hold", rdata_o, 32'h0000_80FF);
    cyc(); valid_i = 1'b0;

    // sh with unsigned code at upper half: folds to half store
    cyc(); drive(1'b1, 1'b0, 3'd2, 32'h0000_2002, 32'hCAFE_BEEF);
    smp();
    cyc(); dmem_ack_i = 1'b1;
    smp(); chk("sh_be", 32'(dmem_be_o), 32'b1100); chk("sh_wdata", dmem_wdata_o, 32'hBEEF_BEEF);
    cyc(); dmem_ack_i = 1'b0; valid_i = 1'b0;

    // lw misaligned 0x2002
    cyc(); drive(1'b0, 1'b1, 3'd0, 32'h0000_2002, 32'h0);
    smp(); chk("mis_pulse", 32'(misalign_o), 32'd1); chk("mis_stall", 32'(stall_o), 32'd0);
    cyc(); valid_i = 1'b0;
    smp(); chk("mis_req", 32'(dmem_req_o), 32'd0); chk("mis_clear", 32'(misalign_o), 32'd0);

    // stray ack in IDLE
    cyc(); dmem_ack_i = 1'b1; dmem_rdata_i = 32'h5555_5555;
    smp(); chk("stray_req", 32'(dmem_req_o), 32'd0);
    cyc(); dmem_ack_i = 1'b0;
    smp(); chk("stray_rvalid", 32'(rdata_valid_o), 32'd0); chk("stray_hold", rdata_o, 32'h0000_80FF);

    // lh 0x3000 with delayed ack; inputs disturbed while BUSY
    cyc(); drive(1'b0, 1'b1, 3'd1, 32'h0000_3000, 32'h0);
    smp();
    cyc(); valid_i = 1'b0; addr_i = 32'hFFFF_FFFF;
    for (int i = 0; i < DLY; i++) begin
      smp(); chk("dly_req", 32'(dmem_req_o), 32'd1); chk("dly_addr", dmem_addr_o, 32'h0000_3000);
      chk("dly_stall", 32'(stall_o), 32'd1);
      cyc();
    end
    dmem_ack_i = 1'b1; dmem_rdata_i = 32'h0000_8001;
    smp(); chk("dly_last_req", 32'(dmem_req_o), 32'd1); chk("dly_last_rvalid", 32'(rdata_valid_o), 32'd0);
    cyc(); dmem_ack_i = 1'b0;
    smp(); chk("dly_rvalid", 32'(rdata_valid_o), 32'd1); chk("dly_rdata", rdata_o, 32'hFFFF_8001);
    chk("dly_done_req", 32'(dmem_req_o), 32'd0);
    cyc();

    // reset while BUSY
    cyc(); drive(1'b1, 1'b0, 3'd0, 32'h0000_4000, 32'hDEAD_BEEF);
    smp();
    cyc(); valid_i = 1'b0;
    smp(); chk("rb_req", 32'(dmem_req_o), 32'd1); chk("rb_wdata", dmem_wdata_o, 32'hDEAD_BEEF);
    #2 rstn = 1'b0;
    #1 chk("rb_req_drop", 32'(dmem_req_o), 32'd0); chk("rb_stall", 32'(stall_o), 32'd0);
    #1 rstn = 1'b1;
    smp(); chk("rb_idle_req", 32'(dmem_req_o), 32'd0); chk("rb_idle_stall", 32'(stall_o), 32'd0);
    cyc(); dmem_ack_i = 1'b1;
    smp(); chk("rb_no_rvalid", 32'(rdata_valid_o), 32'd0);
    cyc(); dmem_ack_i = 1'b0;
    smp(); chk("rb_no_rvalid2", 32'(rdata_valid_o), 32'd0);

`ifdef DMEM_TIMEOUT_EN
    // lw 0x5000, never acknowledged
    cyc(); drive(1'b0, 1'b1, 3'd0, 32'h0000_5000, 32'h0);
    smp();
    cyc(); valid_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      smp(); chk("to_req", 32'(dmem_req_o), 32'd1); chk("to_err_low", 32'(err_o), 32'd0);
      cyc();
    end
    smp(); chk("to_err", 32'(err_o), 32'd1); chk("to_stall", 32'(stall_o), 32'd0);
    chk("to_rvalid", 32'(rdata_valid_o), 32'd0); chk("to_rdata", rdata_o, 32'h0);
    chk("to_req_drop", 32'(dmem_req_o), 32'd0);
    cyc();
    smp(); chk("to_err_clear", 32'(err_o), 32'd0);
`else
    chk("no_to_err", 32'(err_o), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
